// File: rtl/grey_stream_ctrl_if.sv
// Stream, datapath-return and config signals of grey_stream_ctrl.
// master = stream/datapath side, slave = the controller.
interface grey_stream_ctrl_if #(
    parameter int CNT_W = 12
);
    logic [15:0]      i_rgbdata;
    logic             i_de;
    logic             i_vs;
    logic [15:0]      i_grey16;
    logic [7:0]       i_grey8;
    logic             i_grey_de;
    logic             i_grey_vs;
    logic             i_cfg_valid;
    logic [1:0]       i_cfg_mode;
    logic [7:0]       i_cfg_thresh;
    logic             o_cfg_ready;
    logic [1:0]       o_mode;
    logic [15:0]      o_data;
    logic             o_de;
    logic             o_vs;
    logic             o_frame_done;
    logic [CNT_W-1:0] o_frame_lines;
    logic [CNT_W-1:0] o_line_pixels;
    logic             o_geom_err;

    modport master (
        output i_rgbdata, i_de, i_vs, i_grey16, i_grey8, i_grey_de, i_grey_vs,
               i_cfg_valid, i_cfg_mode, i_cfg_thresh,
        input  o_cfg_ready, o_mode, o_data, o_de, o_vs, o_frame_done,
               o_frame_lines, o_line_pixels, o_geom_err
    );

    modport slave (
        input  i_rgbdata, i_de, i_vs, i_grey16, i_grey8, i_grey_de, i_grey_vs,
               i_cfg_valid, i_cfg_mode, i_cfg_thresh,
        output o_cfg_ready, o_mode, o_data, o_de, o_vs, o_frame_done,
               o_frame_lines, o_line_pixels, o_geom_err
    );
endinterface

// File: rtl/grey_stream_ctrl.sv
// Output-mode sequencer for the RGB565-to-grey datapath: per-frame mode
// switching, bypass alignment and frame geometry measurement.
//
// state     | meaning
// ----------+-----------------------------------------------------
// ST_IDLE   | no frame start seen since reset
// ST_VBLANK | inside a frame, waiting for the first/next active line
// ST_ACTIVE | inside a frame, lines being counted
module grey_stream_ctrl #(
    parameter int         LAT        = 2,
    parameter int         CNT_W      = 12,
    parameter logic [1:0] RST_MODE   = 2'd1,
    parameter logic [7:0] RST_THRESH = 8'd128
) (
    input logic               i_clk,
    input logic               i_rst_n,
    grey_stream_ctrl_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_VBLANK = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [15:0]      rgb_dly [LAT];
    logic             grey_vs_q;
    logic             grey_de_q;
    logic             frame_start;
    logic [1:0]       state;
    logic [1:0]       mode_q;
    logic [7:0]       thresh_q;
    logic             pend_valid;
    logic [1:0]       pend_mode;
    logic [7:0]       pend_thresh;
    logic             cfg_accept;
    logic             cfg_apply;
    logic [15:0]      sel_data;
    logic [15:0]      data_q;
    logic             de_q;
    logic             vs_q;
    logic             done_q;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] line_cnt;
    logic [CNT_W-1:0] ref_pix;
    logic             frame_err;
    logic [CNT_W-1:0] lines_q;
    logic [CNT_W-1:0] pixels_q;
    logic             geom_err_q;
    logic             unused_raw;

    // Raw timing only matters to the datapath; alignment follows grey timing.
    assign unused_raw  = bus.i_de ^ bus.i_vs;
    assign frame_start = bus.i_grey_vs & ~grey_vs_q;
    assign cfg_accept  = bus.i_cfg_valid & ~pend_valid;
    assign cfg_apply   = pend_valid & (frame_start | (state == ST_IDLE));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < LAT; i++) rgb_dly[i] <= '0;
        end else begin
            rgb_dly[0] <= bus.i_rgbdata;
            for (int i = 1; i < LAT; i++) rgb_dly[i] <= rgb_dly[i-1];
        end
    end

    always_comb begin
        sel_data = '0;
        if (bus.i_grey_de) begin
            case (mode_q)
                2'd0:    sel_data = rgb_dly[LAT-1];
                2'd1:    sel_data = bus.i_grey16;
                2'd2:    sel_data = (bus.i_grey8 >= thresh_q) ? 16'hFFFF : 16'h0000;
                default: sel_data = ~bus.i_grey16;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q    <= '0;
            de_q      <= 1'b0;
            vs_q      <= 1'b0;
            grey_vs_q <= 1'b0;
            grey_de_q <= 1'b0;
        end else begin
            data_q    <= sel_data;
            de_q      <= bus.i_grey_de;
            vs_q      <= bus.i_grey_vs;
            grey_vs_q <= bus.i_grey_vs;
            grey_de_q <= bus.i_grey_de;
        end
    end

    // A request captured on a frame-start cycle is not yet pending, so it
    // waits for the following frame start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_q      <= RST_MODE;
            thresh_q    <= RST_THRESH;
            pend_valid  <= 1'b0;
            pend_mode   <= '0;
            pend_thresh <= '0;
        end else if (cfg_apply) begin
            mode_q     <= pend_mode;
            thresh_q   <= pend_thresh;
            pend_valid <= 1'b0;
        end else if (cfg_accept) begin
            pend_valid  <= 1'b1;
            pend_mode   <= bus.i_cfg_mode;
            pend_thresh <= bus.i_cfg_thresh;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            ref_pix    <= '0;
            frame_err  <= 1'b0;
            done_q     <= 1'b0;
            lines_q    <= '0;
            pixels_q   <= '0;
            geom_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (frame_start) begin
                if (state != ST_IDLE && line_cnt != '0) begin
                    done_q     <= 1'b1;
                    lines_q    <= line_cnt;
                    pixels_q   <= ref_pix;
                    geom_err_q <= frame_err;
                end
                state     <= ST_VBLANK;
                pix_cnt   <= '0;
                line_cnt  <= '0;
                ref_pix   <= '0;
                frame_err <= 1'b0;
            end else begin
                case (state)
                    ST_VBLANK: begin
                        if (bus.i_grey_de && !grey_de_q) begin
                            state   <= ST_ACTIVE;
                            pix_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                    ST_ACTIVE: begin
                        if (bus.i_grey_de) begin
                            if (pix_cnt == CNT_MAX) frame_err <= 1'b1;
                            else                    pix_cnt   <= pix_cnt + 1'b1;
                        end else if (grey_de_q) begin
                            if (line_cnt == CNT_MAX) frame_err <= 1'b1;
                            else                     line_cnt  <= line_cnt + 1'b1;
                            if (line_cnt == '0)          ref_pix   <= pix_cnt;
                            else if (pix_cnt != ref_pix) frame_err <= 1'b1;
                            pix_cnt <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.o_cfg_ready   = ~pend_valid;
    assign bus.o_mode        = mode_q;
    assign bus.o_data        = data_q;
    assign bus.o_de          = de_q;
    assign bus.o_vs          = vs_q;
    assign bus.o_frame_done  = done_q;
    assign bus.o_frame_lines = lines_q;
    assign bus.o_line_pixels = pixels_q;
    assign bus.o_geom_err    = geom_err_q;
endmodule

// File: tb/tb_grey_stream_ctrl.sv
// Randomized frame bench for grey_stream_ctrl; the bench also plays the
// 2-cycle grey datapath and predicts outputs from a frame-level model.
module tb_grey_stream_ctrl;
    localparam int CNT_W = 12;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    grey_stream_ctrl_if #(.CNT_W(CNT_W)) bus ();

    grey_stream_ctrl #(
        .LAT(2), .CNT_W(CNT_W), .RST_MODE(2'd1), .RST_THRESH(8'd128)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    typedef struct packed {
        logic [15:0] rgb;
        logic        de;
        logic        vs;
        logic [15:0] g16;
        logic [7:0]  g8;
    } pix_t;

    pix_t pipe [3];
    int   checks   = 0;
    int   failures = 0;

    logic       cfg_v = 1'b0;
    logic [1:0] cfg_m = '0;
    logic [7:0] cfg_t = '0;

    int m_mode, m_thr, p_mode, p_thr, m_run;
    bit m_pend, m_seen, m_prev_vs, m_prev_de;
    int lines [$];
    int e_lines, e_pix, e_data;
    bit e_err, e_done, e_de, e_vs;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode = 1; m_thr = 128; m_pend = 0; p_mode = 0; p_thr = 0;
        m_seen = 0; m_prev_vs = 0; m_prev_de = 0; m_run = 0;
        lines.delete();
        e_lines = 0; e_pix = 0; e_err = 0; e_done = 0;
        e_de = 0; e_vs = 0; e_data = 0;
    endfunction

    function automatic int exp_pixel(pix_t g);
        case (m_mode)
            0:       return int'(g.rgb);
            1:       return int'(g.g16);
            2:       return (int'(g.g8) >= m_thr) ? 65535 : 0;
            default: return 65535 - int'(g.g16);
        endcase
    endfunction

    // One clock of the frame-level model, fed with the grey-aligned pixel.
    function automatic void model_step(pix_t g, bit cv, int cm, int ct);
        bit fs, was_idle;
        e_de   = g.de;
        e_vs   = g.vs;
        e_data = g.de ? exp_pixel(g) : 0;
        fs       = g.vs && !m_prev_vs;
        was_idle = !m_seen;
        e_done   = 0;
        if (fs) begin
            if (m_seen && lines.size() > 0) begin
                e_done  = 1;
                e_lines = lines.size();
                e_pix   = lines[0];
                e_err   = 0;
                foreach (lines[i]) if (lines[i] != lines[0]) e_err = 1;
            end
            lines.delete();
            m_run  = 0;
            m_seen = 1;
        end else if (m_seen) begin
            if (g.de) m_run++;
            else if (m_prev_de) begin
                lines.push_back(m_run);
                m_run = 0;
            end
        end
        if (m_pend && (fs || was_idle)) begin
            m_mode = p_mode; m_thr = p_thr; m_pend = 0;
        end else if (cv && !m_pend) begin
            m_pend = 1; p_mode = cm; p_thr = ct;
        end
        m_prev_vs = g.vs;
        m_prev_de = g.de;
    endfunction

    task automatic step(input bit de, input bit vs);
        pix_t t;
        t.rgb = ($urandom_range(0, 3) == 0) ? 16'hF800 : 16'($urandom);
        t.g16 = ($urandom_range(0, 3) == 0) ? 16'h0841 : 16'($urandom);
        case ($urandom_range(0, 3))
            0:       t.g8 = 8'd99;
            1:       t.g8 = 8'd100;
            2:       t.g8 = 8'd255;
            default: t.g8 = 8'($urandom);
        endcase
        t.de = de;
        t.vs = vs;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = t;
        bus.i_rgbdata    = t.rgb;
        bus.i_de         = de;
        bus.i_vs         = vs;
        bus.i_grey16     = pipe[2].g16;
        bus.i_grey8      = pipe[2].g8;
        bus.i_grey_de    = pipe[2].de;
        bus.i_grey_vs    = pipe[2].vs;
        bus.i_cfg_valid  = cfg_v;
        bus.i_cfg_mode   = cfg_m;
        bus.i_cfg_thresh = cfg_t;
        model_step(pipe[2], cfg_v, int'(cfg_m), int'(cfg_t));
        cfg_v = 1'b0;
        @(posedge i_clk);
        #1;
        chk("o_data",        32'(bus.o_data),        32'(e_data));
        chk("o_de",          32'(bus.o_de),          32'(e_de));
        chk("o_vs",          32'(bus.o_vs),          32'(e_vs));
        chk("o_mode",        32'(bus.o_mode),        32'(m_mode));
        chk("o_cfg_ready",   32'(bus.o_cfg_ready),   32'(!m_pend));
        chk("o_frame_done",  32'(bus.o_frame_done),  32'(e_done));
        chk("o_frame_lines", 32'(bus.o_frame_lines), 32'(e_lines));
        chk("o_line_pixels", 32'(bus.o_line_pixels), 32'(e_pix));
        chk("o_geom_err",    32'(bus.o_geom_err),    32'(e_err));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_data"},   32'(bus.o_data),        32'h0);
        chk({tag, "_de"},     32'(bus.o_de),          32'h0);
        chk({tag, "_vs"},     32'(bus.o_vs),          32'h0);
        chk({tag, "_mode"},   32'(bus.o_mode),        32'h1);
        chk({tag, "_ready"},  32'(bus.o_cfg_ready),   32'h1);
        chk({tag, "_done"},   32'(bus.o_frame_done),  32'h0);
        chk({tag, "_lines"},  32'(bus.o_frame_lines), 32'h0);
        chk({tag, "_pixels"}, 32'(bus.o_line_pixels), 32'h0);
        chk({tag, "_err"},    32'(bus.o_geom_err),    32'h0);
    endtask

    task automatic do_reset();
        #2 i_rst_n = 1'b0;
        #1 check_reset_state("rst_mid");
        model_reset();
        repeat (2) @(posedge i_clk);
        #2 i_rst_n = 1'b1;
    endtask

    // short_line gets one pixel fewer; cfg_line issues a request at that
    // line's first pixel; cfg_at_vs issues one on the grey_vs rising cycle.
    task automatic frame(input int nlines, input int ppl, input int short_line,
                         input int cfg_line, input int cmode, input int cthr,
                         input bit cfg_at_vs, input int rst_line);
        for (int i = 0; i < 3; i++) begin
            if (i == 2 && cfg_at_vs) begin
                cfg_v = 1'b1; cfg_m = 2'(cmode); cfg_t = 8'(cthr);
            end
            step(1'b0, 1'b1);
        end
        repeat (3) step(1'b0, 1'b0);
        for (int l = 0; l < nlines; l++) begin
            int n;
            n = (l == short_line) ? ppl - 1 : ppl;
            for (int p = 0; p < n; p++) begin
                if (p == 0 && l == cfg_line) begin
                    cfg_v = 1'b1;
                    cfg_m = cfg_at_vs ? 2'(cmode ^ 1) : 2'(cmode);
                    cfg_t = 8'(cthr);
                end
                step(1'b1, 1'b0);
                if (l == rst_line && p == 3) do_reset();
            end
            repeat (3) step(1'b0, 1'b0);
        end
        repeat (2) step(1'b0, 1'b0);
    endtask

    initial begin
        bus.i_rgbdata = '0; bus.i_de = 1'b0; bus.i_vs = 1'b0;
        bus.i_grey16 = '0; bus.i_grey8 = '0; bus.i_grey_de = 1'b0; bus.i_grey_vs = 1'b0;
        bus.i_cfg_valid = 1'b0; bus.i_cfg_mode = '0; bus.i_cfg_thresh = '0;
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1 check_reset_state("rst_init");
        i_rst_n = 1'b1;

        repeat (3) frame(4, 8, -1, -1, 0, 0, 1'b0, -1);
        frame(4, 8, -1, 1, 2, 100, 1'b0, -1);
        repeat (2) frame(4, 8, -1, -1, 0, 0, 1'b0, -1);
        frame(4, 8, -1, 2, 0, 0, 1'b0, -1);
        frame(4, 8, -1, -1, 0, 0, 1'b0, -1);
        frame(4, 8, -1, 1, 3, 0, 1'b0, -1);
        frame(4, 8, -1, -1, 0, 0, 1'b0, -1);
        frame(4, 8, 2, -1, 0, 0, 1'b0, -1);
        repeat (2) frame(4, 8, -1, -1, 0, 0, 1'b0, -1);
        frame(4, 8, -1, 1, 2, 50, 1'b1, -1);
        repeat (2) frame(4, 8, -1, -1, 0, 0, 1'b0, -1);
        frame(4, 8, -1, -1, 0, 0, 1'b0, 1);
        repeat (2) frame(4, 8, -1, -1, 0, 0, 1'b0, -1);
        repeat (6) begin
            int nl, pp;
            nl = $urandom_range(2, 5);
            pp = $urandom_range(3, 9);
            frame(nl, pp, $urandom_range(0, 2 * nl), $urandom_range(0, nl),
                  $urandom_range(0, 3), $urandom_range(0, 255), 1'b0, -1);
        end
        frame(3, 5, -1, -1, 0, 0, 1'b0, -1);
        repeat (6) step(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/grey_stream_ctrl.md
Name: grey_stream_ctrl

Overview:
- Controller that sequences the 2-cycle RGB565-to-grey datapath inside the video pipeline: selects the output mode per frame, aligns the bypass RGB path to the datapath latency, and measures frame geometry.
- Sits between the camera/DDR read stream and the HDMI/VGA output.
- Takes the raw RGB565 stream plus the datapath's grey outputs.
- Emits one registered stream with its timing signals, a config handshake and frame status.

Parameters:
- LAT, 2, datapath latency in cycles from i_de/i_vs/i_rgbdata to i_grey_*; depth of the bypass delay line.
- CNT_W, 12, width of the pixel and line counters.
- RST_MODE, 2'd1, active mode after reset.
- RST_THRESH, 8'd128, threshold after reset.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_rgbdata  in  16  raw RGB565 pixel
- i_de  in  1  raw data enable
- i_vs  in  1  raw vsync, active high
- i_grey16  in  16  datapath grey in RGB565 form (aligned with i_grey_de)
- i_grey8  in  8  datapath 8-bit grey
- i_grey_de  in  1  datapath delayed de
- i_grey_vs  in  1  datapath delayed vs
- i_cfg_valid  in  1  config request
- i_cfg_mode  in  2  requested mode: 0 bypass, 1 grey, 2 binary, 3 inverted grey
- i_cfg_thresh  in  8  binary threshold
- o_cfg_ready  out  1  config slot free
- o_mode  out  2  mode applied to the current frame
- o_data  out  16  output pixel
- o_de  out  1  output data enable
- o_vs  out  1  output vsync
- o_frame_done  out  1  one-cycle pulse at frame start after a completed frame
- o_frame_lines  out  CNT_W  line count of the last completed frame
- o_line_pixels  out  CNT_W  pixel count of the first line of the last completed frame
- o_geom_err  out  1  last completed frame had unequal line lengths

Behaviour:
- Reset values:
  - o_data, o_de, o_vs, o_frame_done, o_frame_lines, o_line_pixels, o_geom_err = 0.
  - o_mode = RST_MODE; active threshold = RST_THRESH; o_cfg_ready = 1; pending empty; FSM = IDLE.
- Bypass path: i_rgbdata delayed LAT registers. All output-side decisions use i_grey_de/i_grey_vs as timing reference.
- Output latency: o_data/o_de/o_vs registered one cycle after i_grey_*, i.e. LAT+1 = 3 cycles after i_de/i_vs.
- o_data selection by o_mode; 0 whenever i_grey_de = 0:
  - mode 0: delayed RGB.
  - mode 1: i_grey16.
  - mode 2: 16'hFFFF if i_grey8 >= thresh (unsigned), else 16'h0000.
  - mode 3: ~i_grey16.
- Config handshake:
  - Transfer when i_cfg_valid & o_cfg_ready; mode and threshold captured into a pending register; o_cfg_ready drops the next cycle.
  - Pending is applied (o_mode, thresh updated; o_cfg_ready returns to 1) at the cycle a frame start is detected, or on the next cycle if the FSM is in IDLE.
  - Frame start = rising edge of i_grey_vs.
  - Capture and frame start in the same cycle: the captured config waits for the next frame start. The current frame uses the prior mode.
- FSM:
  - IDLE: no frame seen. On frame start -> VBLANK; counters cleared.
  - VBLANK: on i_grey_de rising -> ACTIVE.
  - ACTIVE:
    - Pixel counter increments per i_grey_de cycle.
    - On i_grey_de falling: line counter +1; first line's pixel count stored as reference; later lines compared against it and a mismatch sets a frame error flag; pixel counter cleared.
    - On frame start -> VBLANK.
  - Frame start in VBLANK/ACTIVE with line counter > 0:
    - o_frame_done pulses one cycle.
    - o_frame_lines, o_line_pixels, o_geom_err latched.
    - Internal counters and error flag cleared.
  - Frame start with zero lines: no pulse; status unchanged.
- Counters saturate at all-ones; no wrap. Saturation of either counter sets the frame error flag.
- Asynchronous reset mid-frame: everything returns to reset values; FSM = IDLE. The partial frame is discarded and produces no o_frame_done.
- i_grey_de high in IDLE: data still passes in the current mode; not counted.

Test Plan:
- Reset then 3 frames of 4 lines x 8 pixels, mode 1 -> o_data = i_grey16 3 cycles after i_de; o_frame_done at frames 2 and 3 starts; o_frame_lines = 4, o_line_pixels = 8, o_geom_err = 0.
- cfg mode 2, thresh 8'd100, issued mid-frame -> o_cfg_ready low until next frame start; pixels with grey8 = 99/100/255 give 0000/FFFF/FFFF only from the new frame.
- Mode 0 with i_rgbdata = 16'hF800 -> o_data = 16'hF800 aligned with o_de; mode 3 with i_grey16 = 16'h0841 -> 16'hF7BE.
- Frame whose third line has 7 pixels -> o_geom_err = 1 at next o_frame_done; following clean frame -> 0.
- cfg_valid asserted in the same cycle as an i_grey_vs rising edge -> new mode applies one frame later; second cfg_valid while pending is not accepted.
- Reset asserted mid-ACTIVE -> all outputs 0, o_mode = 1 immediately; first frame after release produces no o_frame_done.
